// File: rtl/ldadd_xbar_pipe_if.sv
// Request, result and table-programming bundle for ldadd_xbar_pipe.
// Latency: none, wires only.
// Backpressure: carries o_rdy (request side) and i_ack (result side).
interface ldadd_xbar_pipe_if #(
    parameter int LANES  = 12,
    parameter int DATA_W = 16,
    parameter int ENT    = 8
);
    localparam int SEL_W = $clog2(LANES);
    localparam int FN_W  = $clog2(ENT);
    localparam int EA_W  = FN_W + SEL_W;

    // request side
    logic                    i_req;
    logic                    o_rdy;
    logic [FN_W-1:0]         i_func;
    logic                    i_mode;
    logic                    i_clr;
    logic [LANES*DATA_W-1:0] i_dmemin;

    // result side
    logic [LANES*DATA_W-1:0] o_fetch;
    logic                    o_vld;
    logic                    i_ack;

    // table programming bus
    logic                    i_exwe;
    logic                    i_exre;
    logic [EA_W-1:0]         i_exa;
    logic [DATA_W-1:0]       i_exwd;
    logic [DATA_W-1:0]       o_exrd;

    modport master (
        output i_req, i_func, i_mode, i_clr, i_dmemin, i_ack,
        output i_exwe, i_exre, i_exa, i_exwd,
        input  o_rdy, o_fetch, o_vld, o_exrd
    );

    modport slave (
        input  i_req, i_func, i_mode, i_clr, i_dmemin, i_ack,
        input  i_exwe, i_exre, i_exa, i_exwd,
        output o_rdy, o_fetch, o_vld, o_exrd
    );
endinterface

// File: rtl/ldadd_xbar_pipe.sv
// Load-side lane crossbar: permutes a memory word and merges it, lane-masked, into the fetch register.
// Latency: request accepted at edge t updates o_fetch/o_vld at edge t+1; one request per cycle sustained.
// Backpressure: stage 1 holds while a result is unacked; o_rdy drops when stage 1 cannot drain.
module ldadd_xbar_pipe #(
    parameter int LANES  = 12,
    parameter int DATA_W = 16,
    parameter int ENT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ldadd_xbar_pipe_if.slave  bus
);
    localparam int SEL_W = $clog2(LANES);
    localparam int FN_W  = $clog2(ENT);
    localparam int EA_W  = FN_W + SEL_W;
    // lane count sized one bit wider than a lane select so every select value compares cleanly
    localparam logic [SEL_W:0] LANES_C = (SEL_W+1)'(LANES);

    // crossbar/mask table: per entry a lane select and a merge-enable per destination lane
    logic [SEL_W-1:0]  sel_q [ENT][LANES];
    logic [LANES-1:0]  map_q [ENT];

    // stage 1 holding register
    logic              s1_vld;
    logic [DATA_W-1:0] s1_lane [LANES];
    logic [FN_W-1:0]   s1_func;
    logic              s1_mode;

    // stage 2 fetch register
    logic [DATA_W-1:0] fetch_q [LANES];
    logic [DATA_W-1:0] fetch_d [LANES];
    logic [DATA_W-1:0] fin_lane [LANES];
    logic              vld_q;

    // table read-back register
    logic [DATA_W-1:0] exrd_q;
    logic [DATA_W-1:0] rd_w;

    logic              commit;
    logic              rdy;
    logic              accept;

    logic [FN_W-1:0]   ex_ent;
    logic [SEL_W-1:0]  ex_lane;
    logic              ex_lane_ok;

    // stage 1 drains whenever the result slot is empty or being consumed this cycle
    assign commit = s1_vld & (~vld_q | bus.i_ack);
    assign rdy    = ~s1_vld | commit;
    assign accept = bus.i_req & rdy;

    assign ex_ent     = bus.i_exa[EA_W-1:SEL_W];
    assign ex_lane    = bus.i_exa[SEL_W-1:0];
    assign ex_lane_ok = ({1'b0, ex_lane} < LANES_C);

    assign bus.o_rdy  = rdy;
    assign bus.o_vld  = vld_q;
    assign bus.o_exrd = exrd_q;

    for (genvar g = 0; g < LANES; g++) begin : g_pack
        assign bus.o_fetch[g*DATA_W +: DATA_W] = fetch_q[g];
    end

    // upper write-data bits carry no meaning; fold them so they are visibly consumed
    if (DATA_W > SEL_W + 1) begin : g_exwd_hi
        logic unused_exwd_hi;
        assign unused_exwd_hi = ^bus.i_exwd[DATA_W-1:SEL_W+1];
    end

    // crossbar: each destination lane picks its source lane; out-of-range selects read as zero
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            fin_lane[k] = '0;
            if ({1'b0, sel_q[s1_func][k]} < LANES_C) begin
                fin_lane[k] = s1_lane[sel_q[s1_func][k]];
            end
        end
    end

    // merge: clear applies first, then masked lanes take fin (overwrite) or base+fin (accumulate)
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            fetch_d[k] = bus.i_clr ? '0 : fetch_q[k];
            if (commit && map_q[s1_func][k]) begin
                fetch_d[k] = s1_mode ? (fetch_d[k] + fin_lane[k]) : fin_lane[k];
            end
        end
    end

    // table read word: {map, sel} zero-extended, zero for a nonexistent lane
    always_comb begin
        rd_w = '0;
        if (ex_lane_ok) begin
            rd_w[SEL_W-1:0] = sel_q[ex_ent][ex_lane];
            rd_w[SEL_W]     = map_q[ex_ent][ex_lane];
        end
    end

    // stage 1: capture on accept, empty on commit without a fresh accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_func <= '0;
            s1_mode <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_lane[k] <= '0;
            end
        end else if (accept) begin
            s1_vld  <= 1'b1;
            s1_func <= bus.i_func;
            s1_mode <= bus.i_mode;
            for (int k = 0; k < LANES; k++) begin
                s1_lane[k] <= bus.i_dmemin[k*DATA_W +: DATA_W];
            end
        end else if (commit) begin
            s1_vld <= 1'b0;
        end
    end

    // stage 2: fetch register and result-valid; a commit keeps o_vld set even when acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                fetch_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                fetch_q[k] <= fetch_d[k];
            end
            if (commit) begin
                vld_q <= 1'b1;
            end else if (bus.i_clr || (bus.i_ack && vld_q)) begin
                vld_q <= 1'b0;
            end
        end
    end

    // table write: lookups this cycle still see the old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENT; e++) begin
                map_q[e] <= '0;
                for (int k = 0; k < LANES; k++) begin
                    sel_q[e][k] <= '0;
                end
            end
        end else if (bus.i_exwe && ex_lane_ok) begin
            sel_q[ex_ent][ex_lane] <= bus.i_exwd[SEL_W-1:0];
            map_q[ex_ent][ex_lane] <= bus.i_exwd[SEL_W];
        end
    end

    // table read: registered, holds between strobes, returns pre-write data on a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exrd_q <= '0;
        end else if (bus.i_exre) begin
            exrd_q <= rd_w;
        end
    end

endmodule
